// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding / hazard unit.
//   kind_e     : producer class carried down the pipeline with each writer
//   fwd_rec_t  : one downstream writer record (valid, rd, we, kind)
//   FWD_RF     : stage select meaning "read the register file"
//   is_link()  : producer's forwarded value is PC+4, not its result
package fwd_pkg;

    typedef enum logic [1:0] {
        NO_JUMP = 2'b00,
        JAL     = 2'b01,
        JAL_R   = 2'b10,
        LOAD    = 2'b11
    } kind_e;

    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        kind_e      kind;
    } fwd_rec_t;

    function automatic logic is_link(input kind_e kind);
        return (kind == JAL) || (kind == JAL_R);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher: compares one EX source register against the DEPTH
// downstream writer records and reports the youngest match.
//   rs   in  : EX source register
//   recs in  : writer records, index 1 = MEM (youngest) .. DEPTH (oldest)
//   hit  out : some record matches
//   k    out : stage of the youngest match (FWD_RF when no hit)
//   kind out : producer kind of the youngest match
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SW    = $clog2(DEPTH + 1)
) (
    input  logic [4:0]           rs,
    input  fwd_rec_t [DEPTH:1]   recs,
    output logic                 hit,
    output logic [SW-1:0]        k,
    output kind_e                kind
);

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit  = 1'b0;
        k    = SW'(FWD_RF);
        kind = NO_JUMP;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (recs[DEPTH-j].valid && recs[DEPTH-j].we &&
                recs[DEPTH-j].rd == rs && rs != 5'd0) begin
                hit  = 1'b1;
                k    = SW'(DEPTH - j);
                kind = recs[DEPTH-j].kind;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit sitting beside the EX stage.
//   clk, rst      : clock, asynchronous active-high reset
//   ex_valid/ex_rd/ex_reg_we/ex_kind : EX writer info, enters stage 1
//   ex_rs         : NUM_SRC packed 5-bit EX source registers
//   ext_stall     : pipeline freeze, all records hold
//   fwd_stage     : per operand, 0 = register file, k = forward from stage k
//   fwd_link      : per operand, forward PC+4 of that stage instead of result
//   hazard_stall  : load-use stall, bubble into stage 1
//   stall_count   : cycles with hazard_stall=1 and ext_stall=0 (wraps)
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SW       = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [4:0]              ex_rd,
    input  logic                    ex_reg_we,
    input  logic [1:0]              ex_kind,
    input  logic [NUM_SRC*5-1:0]    ex_rs,
    input  logic                    ext_stall,
    output logic [NUM_SRC*SW-1:0]   fwd_stage,
    output logic [NUM_SRC-1:0]      fwd_link,
    output logic                    hazard_stall,
    output logic [CNT_W-1:0]        stall_count
);

    fwd_rec_t [DEPTH:1] rec;
    fwd_rec_t           ex_rec;

    logic [NUM_SRC-1:0] hit;
    logic [SW-1:0]      k_sel    [NUM_SRC];
    kind_e              kind_sel [NUM_SRC];
    logic [NUM_SRC-1:0] load_use;

    always_comb begin
        ex_rec.valid = ex_valid;
        ex_rec.rd    = ex_rd;
        ex_rec.we    = ex_reg_we;
        ex_rec.kind  = kind_e'(ex_kind);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec <= '0;
        end else if (!ext_stall) begin
            for (int unsigned s = 2; s <= DEPTH; s++) begin
                rec[s] <= rec[s-1];
            end
            rec[1] <= hazard_stall ? fwd_rec_t'('0) : ex_rec;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        fwd_match #(
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_match (
            .rs   (ex_rs[5*i +: 5]),
            .recs (rec),
            .hit  (hit[i]),
            .k    (k_sel[i]),
            .kind (kind_sel[i])
        );
    end

    // Only the winning match matters: an older load behind a younger
    // non-load writer of the same register never stalls.
    always_comb begin
        load_use = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            load_use[i] = hit[i] && (kind_sel[i] == LOAD) &&
                          (32'(k_sel[i]) <= LOAD_LAT);
        end
    end

    assign hazard_stall = |load_use;

    always_comb begin
        fwd_stage = '0;
        fwd_link  = '0;
        if (!hazard_stall) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                fwd_stage[i*SW +: SW] = hit[i] ? k_sel[i] : SW'(FWD_RF);
                fwd_link[i]           = hit[i] && is_link(kind_sel[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard_stall && !ext_stall) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned SW      = 2;

    logic                  clk;
    logic                  rst;
    logic                  ex_valid;
    logic [4:0]            ex_rd;
    logic                  ex_reg_we;
    logic [1:0]            ex_kind;
    logic [NUM_SRC*5-1:0]  ex_rs;
    logic                  ext_stall;
    logic [NUM_SRC*SW-1:0] fwd_stage;
    logic [NUM_SRC-1:0]    fwd_link;
    logic                  hazard_stall;
    logic [31:0]           stall_count;

    fwd_hazard_unit #(
        .NUM_SRC  (2),
        .DEPTH    (3),
        .LOAD_LAT (1),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_rd        (ex_rd),
        .ex_reg_we    (ex_reg_we),
        .ex_kind      (ex_kind),
        .ex_rs        (ex_rs),
        .ext_stall    (ext_stall),
        .fwd_stage    (fwd_stage),
        .fwd_link     (fwd_link),
        .hazard_stall (hazard_stall),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  kind;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic        xs;
        logic [1:0]  fs0;
        logic [1:0]  fs1;
        logic [1:0]  lk;
        logic        hz;
        logic [31:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [3:0]  fs;
        logic [1:0]  lk;
        logic        hz;
        logic [31:0] cnt;
    } exp_t;

    localparam int NV = 25;
    vec_t tv [NV];
    exp_t sb [$];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(input logic v, input int rd, input logic we,
                                input int kind, input int rs0, input int rs1,
                                input logic xs, input int fs0, input int fs1,
                                input int lk, input logic hz, input int cnt);
        vec_t r;
        r.v = v;   r.rd = 5'(rd);   r.we = we;   r.kind = 2'(kind);
        r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.xs = xs;
        r.fs0 = 2'(fs0); r.fs1 = 2'(fs1); r.lk = 2'(lk); r.hz = hz;
        r.cnt = 32'(cnt);
        return r;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t got;
        got = '{fs: fwd_stage, lk: fwd_link, hz: hazard_stall, cnt: stall_count};
        n_vec++;
        if (got !== e) begin
            n_miss++;
            $display("FAIL %s: got fwd_stage=%h fwd_link=%b hazard_stall=%b stall_count=%0d, want fwd_stage=%h fwd_link=%b hazard_stall=%b stall_count=%0d",
                     name, got.fs, got.lk, got.hz, got.cnt, e.fs, e.lk, e.hz, e.cnt);
        end
    endtask

    task automatic drive(input logic v, input int rd, input logic we,
                         input int kind, input int rs0, input int rs1, input logic xs);
        ex_valid  = v;
        ex_rd     = 5'(rd);
        ex_reg_we = we;
        ex_kind   = 2'(kind);
        ex_rs     = {5'(rs1), 5'(rs0)};
        ext_stall = xs;
    endtask

    initial begin
        exp_t e;
        string nm;

        // kind: 0 ALU, 1 JAL, 2 JAL_R, 3 LOAD
        //            v  rd we k  rs0 rs1 xs fs0 fs1 lk hz cnt
        tv[0]  = mk(1,  5, 1, 0,  0,  0, 0,  0,  0, 0, 0, 0);  // ALU writes x5
        tv[1]  = mk(0,  0, 0, 0,  5,  0, 0,  1,  0, 0, 0, 0);  // x5 from stage 1
        tv[2]  = mk(0,  0, 0, 0,  5,  0, 0,  2,  0, 0, 0, 0);  // from stage 2
        tv[3]  = mk(0,  0, 0, 0,  5,  0, 0,  3,  0, 0, 0, 0);  // from stage 3
        tv[4]  = mk(0,  0, 0, 0,  5,  0, 0,  0,  0, 0, 0, 0);  // dropped off
        tv[5]  = mk(1,  7, 1, 3,  0,  0, 0,  0,  0, 0, 0, 0);  // LOAD x7
        tv[6]  = mk(1,  9, 1, 0,  0,  7, 0,  0,  0, 0, 1, 0);  // load-use stall
        tv[7]  = mk(1,  9, 1, 0,  0,  7, 0,  0,  2, 0, 0, 1);  // replay, fwd 2
        tv[8]  = mk(1,  1, 1, 1,  0,  0, 0,  0,  0, 0, 0, 1);  // JAL x1
        tv[9]  = mk(0,  0, 0, 0,  1,  9, 0,  1,  2, 1, 0, 1);  // link fwd
        tv[10] = mk(1,  1, 1, 2,  0,  9, 0,  0,  3, 0, 0, 1);  // JAL_R x1
        tv[11] = mk(1,  3, 1, 0,  1,  0, 0,  1,  0, 1, 0, 1);  // JAL_R youngest
        tv[12] = mk(1,  3, 1, 0,  0,  3, 0,  0,  1, 0, 0, 1);  // x3 again
        tv[13] = mk(1,  0, 1, 0,  3,  1, 0,  1,  3, 2, 0, 1);  // priority, link@3
        tv[14] = mk(1,  4, 0, 0,  0,  0, 0,  0,  0, 0, 0, 1);  // x0 reader
        tv[15] = mk(1,  0, 1, 3,  4,  0, 0,  0,  0, 0, 0, 1);  // we=0 no fwd
        tv[16] = mk(0,  6, 1, 0,  0,  0, 0,  0,  0, 0, 0, 1);  // LOAD x0 no stall
        tv[17] = mk(0,  0, 0, 0,  6,  0, 0,  0,  0, 0, 0, 1);  // invalid writer
        tv[18] = mk(1,  8, 1, 3,  0,  0, 0,  0,  0, 0, 0, 1);  // LOAD x8
        tv[19] = mk(1, 10, 1, 0,  8,  0, 1,  0,  0, 0, 1, 1);  // frozen
        tv[20] = mk(1, 10, 1, 0,  8,  0, 1,  0,  0, 0, 1, 1);
        tv[21] = mk(1, 10, 1, 0,  8,  0, 1,  0,  0, 0, 1, 1);
        tv[22] = mk(1, 10, 1, 0,  8,  0, 0,  0,  0, 0, 1, 1);  // released
        tv[23] = mk(1, 10, 1, 0,  8,  0, 0,  2,  0, 0, 0, 2);
        tv[24] = mk(1, 11, 1, 3,  0, 10, 0,  0,  1, 0, 0, 2);  // LOAD x11

        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 0, 0, 0, 1'b0);
        @(negedge clk);
        check("reset_state", '{fs: 4'h0, lk: 2'b00, hz: 1'b0, cnt: 32'd0});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tv[i].v, int'(tv[i].rd), tv[i].we, int'(tv[i].kind),
                  int'(tv[i].rs0), int'(tv[i].rs1), tv[i].xs);
            sb.push_back('{fs: {tv[i].fs1, tv[i].fs0}, lk: tv[i].lk,
                           hz: tv[i].hz, cnt: tv[i].cnt});
            @(negedge clk);
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL scoreboard_empty: got 0 entries, want 1");
            end else begin
                e = sb.pop_front();
                nm = $sformatf("vec%0d", i);
                check(nm, e);
            end
        end

        // Async reset in the middle of a load-use hazard on x11.
        @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b0, 0, 11, 10, 1'b0);
        #1;
        check("pre_reset_stall", '{fs: 4'h0, lk: 2'b00, hz: 1'b1, cnt: 32'd2});
        rst = 1'b1;
        #1;
        check("async_reset", '{fs: 4'h0, lk: 2'b00, hz: 1'b0, cnt: 32'd0});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 0, 1'b0, 0, 11, 10, 1'b0);
        @(negedge clk);
        check("post_reset_read", '{fs: 4'h0, lk: 2'b00, hz: 1'b0, cnt: 32'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
